// File: rtl/video_pkg.sv
// Shared defaults, derived widths and bit-reverse helper for the video output dither path.
`default_nettype none

package video_pkg;

  localparam int COMP_W_DEF = 5;
  localparam int DAC_W_DEF  = 2;
  localparam int PH_W_DEF   = 2;

  // CRAM word: {dac_mode, red, green, blue}
  function automatic int cram_width(input int comp_w);
    return 3 * comp_w + 1;
  endfunction

  function automatic int frac_width(input int comp_w, input int dac_w);
    return comp_w - dac_w;
  endfunction

  function automatic logic [7:0] bitreverse(input logic [7:0] v);
    return {<<{v}};
  endfunction

endpackage

`default_nettype wire

// File: rtl/video_cram.sv
// 256-entry colour RAM: CPU write/read-back port plus registered pixel read port.
`default_nettype none

module video_cram #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [7:0]    cpu_addr,
  input  logic [CW-1:0] wdata,
  output logic [CW-1:0] cpu_rdata,
  input  logic [7:0]    pix_addr,
  output logic [CW-1:0] pix_data
);

  logic [CW-1:0] mem [256];

  always_ff @(posedge clk) begin
    if (we) mem[cpu_addr] <= wdata;
  end

  // Both read ports sample the array before the write lands: old-data on collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_rdata <= '0;
      pix_data  <= '0;
    end else begin
      cpu_rdata <= mem[cpu_addr];
      pix_data  <= mem[pix_addr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/video_out_dither.sv
// Pixel index select, CRAM lookup and ordered-dither reduction of each colour
// component to the DAC width, three-stage pipeline with blank carried alongside.
`default_nettype none

module video_out_dither
  import video_pkg::*;
#(
  parameter int  COMP_W = COMP_W_DEF,
  parameter int  DAC_W  = DAC_W_DEF,
  parameter int  PH_W   = PH_W_DEF,
  localparam int CW     = cram_width(COMP_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c3,
  input  logic              vga_on,
  input  logic              tv_blank,
  input  logic              vga_blank,
  input  logic              vga_line,
  input  logic [1:0]        plex_sel_in,
  input  logic              tv_hires,
  input  logic              vga_hires,
  input  logic [3:0]        palsel,
  input  logic [7:0]        vplex_in,
  input  logic [7:0]        vgaplex,
  input  logic [7:0]        cram_addr_in,
  input  logic [CW-1:0]     cram_data_in,
  input  logic              cram_we,
  output logic [CW-1:0]     cram_rd_data,
  output logic [DAC_W-1:0]  vred,
  output logic [DAC_W-1:0]  vgrn,
  output logic [DAC_W-1:0]  vblu,
  output logic [COMP_W-1:0] vred_raw,
  output logic [COMP_W-1:0] vgrn_raw,
  output logic [COMP_W-1:0] vblu_raw,
  output logic              vdac_mode
);

  localparam int F = frac_width(COMP_W, DAC_W);

  logic [7:0]    tv_idx;
  logic [7:0]    plex;
  logic          hires;
  logic          sel;
  logic          blank_in;
  logic [7:0]    idx;
  logic [7:0]    idx_s1;
  logic          blank_s1;
  logic          blank_s2;
  logic [CW-1:0] word_s2;
  logic [PH_W-1:0] ph;
  logic [PH_W-1:0] p;
  logic [F-1:0]  thr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     tv_idx <= '0;
    else if (c3) tv_idx <= vplex_in;
  end

  always_comb begin
    plex     = vga_on ? vgaplex     : tv_idx;
    hires    = vga_on ? vga_hires   : tv_hires;
    sel      = vga_on ? plex_sel_in[0] : plex_sel_in[1];
    blank_in = vga_on ? vga_blank   : tv_blank;
    idx      = hires ? {palsel, (sel ? plex[3:0] : plex[7:4])} : plex;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_s1   <= '0;
      blank_s1 <= 1'b0;
      blank_s2 <= 1'b0;
      ph       <= '0;
    end else begin
      idx_s1   <= idx;
      blank_s1 <= blank_in;
      blank_s2 <= blank_s1;
      ph       <= ph + PH_W'(1);
    end
  end

  video_cram #(
    .CW (CW)
  ) u_cram (
    .clk       (clk),
    .rst       (rst),
    .we        (cram_we),
    .cpu_addr  (cram_addr_in),
    .wdata     (cram_data_in),
    .cpu_rdata (cram_rd_data),
    .pix_addr  (idx_s1),
    .pix_data  (word_s2)
  );

  generate
    if (PH_W == 1) begin : g_phase_single
      assign p = ph;
    end else begin : g_phase_multi
      assign p = vga_on ? {vga_line, ph[PH_W-2:0]} : ph;
    end
  endgenerate

  // Reversed phase spreads successive pixels across the fraction range.
  assign thr = F'((bitreverse(8'(p)) >> (8 - PH_W)) << (F - PH_W));

  generate
    for (genvar ch = 0; ch < 3; ch++) begin : g_chan
      logic [COMP_W-1:0] comp;
      logic [DAC_W-1:0]  coarse;
      logic [F-1:0]      frac;
      logic              bump;
      logic [DAC_W-1:0]  dac_q;
      logic [COMP_W-1:0] raw_q;

      assign comp   = word_s2[ch*COMP_W +: COMP_W];
      assign coarse = comp[COMP_W-1:F];
      assign frac   = comp[F-1:0];
      assign bump   = (frac > thr) && (coarse != '1);

      always_ff @(posedge clk or posedge rst) begin
        if (rst || blank_s2) begin
          dac_q <= '0;
          raw_q <= '0;
        end else begin
          dac_q <= coarse + DAC_W'(bump);
          raw_q <= comp;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           vdac_mode <= 1'b0;
    else if (blank_s2) vdac_mode <= 1'b0;
    else               vdac_mode <= word_s2[CW-1];
  end

  assign vblu     = g_chan[0].dac_q;
  assign vgrn     = g_chan[1].dac_q;
  assign vred     = g_chan[2].dac_q;
  assign vblu_raw = g_chan[0].raw_q;
  assign vgrn_raw = g_chan[1].raw_q;
  assign vred_raw = g_chan[2].raw_q;

endmodule

`default_nettype wire

// File: tb/tb_video_out_dither.sv
// Directed scoreboard bench for video_out_dither at default parameters.
`default_nettype none

module tb_video_out_dither;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        c3 = 1'b0, vga_on = 1'b0, tv_blank = 1'b0, vga_blank = 1'b0, vga_line = 1'b0;
  logic [1:0]  plex_sel_in = 2'b00;
  logic        tv_hires = 1'b0, vga_hires = 1'b0;
  logic [3:0]  palsel = 4'h0;
  logic [7:0]  vplex_in = 8'h00, vgaplex = 8'h00, cram_addr_in = 8'h00;
  logic [15:0] cram_data_in = 16'h0000;
  logic        cram_we = 1'b0;
  logic [15:0] cram_rd_data;
  logic [1:0]  vred, vgrn, vblu;
  logic [4:0]  vred_raw, vgrn_raw, vblu_raw;
  logic        vdac_mode;

  video_out_dither dut (
    .clk(clk), .rst(rst), .c3(c3), .vga_on(vga_on), .tv_blank(tv_blank),
    .vga_blank(vga_blank), .vga_line(vga_line), .plex_sel_in(plex_sel_in),
    .tv_hires(tv_hires), .vga_hires(vga_hires), .palsel(palsel),
    .vplex_in(vplex_in), .vgaplex(vgaplex), .cram_addr_in(cram_addr_in),
    .cram_data_in(cram_data_in), .cram_we(cram_we), .cram_rd_data(cram_rd_data),
    .vred(vred), .vgrn(vgrn), .vblu(vblu), .vred_raw(vred_raw),
    .vgrn_raw(vgrn_raw), .vblu_raw(vblu_raw), .vdac_mode(vdac_mode)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          chk;
    logic [21:0] exp;
    string       tag;
  } sb_t;

  sb_t         sbq[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  logic [15:0] shadow [256];
  logic [7:0]  tv_lat;

  function automatic logic [21:0] model(input logic [15:0] w, input logic blank, input int p);
    int         thr_tab [4] = '{0, 4, 2, 6};
    logic [4:0] c [3];
    logic [1:0] d [3];
    if (blank) return '0;
    c[2] = w[14:10];
    c[1] = w[9:5];
    c[0] = w[4:0];
    for (int i = 0; i < 3; i++) begin
      int coarse;
      int frac;
      coarse = int'(c[i][4:3]);
      frac   = int'(c[i][2:0]);
      if (frac > thr_tab[p] && coarse != 3) coarse = coarse + 1;
      d[i] = coarse[1:0];
    end
    return {d[2], d[1], d[0], c[2], c[1], c[0], w[15]};
  endfunction

  function automatic logic [21:0] observed();
    return {vred, vgrn, vblu, vred_raw, vgrn_raw, vblu_raw, vdac_mode};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One pixel clock: predict from current inputs, advance, compare what is due.
  task automatic step(input bit chk, input string tag);
    logic [7:0]  plex, idx;
    logic        hires, sel, blank;
    logic [21:0] obs;
    int          ph, p;
    sb_t         e, o;
    plex  = vga_on ? vgaplex : tv_lat;
    hires = vga_on ? vga_hires : tv_hires;
    sel   = vga_on ? plex_sel_in[0] : plex_sel_in[1];
    blank = vga_on ? vga_blank : tv_blank;
    idx   = hires ? {palsel, (sel ? plex[3:0] : plex[7:4])} : plex;
    if (cram_we) shadow[cram_addr_in] = cram_data_in;
    if (c3) tv_lat = vplex_in;
    ph = (cyc + 2) % 4;
    p  = vga_on ? (int'(vga_line) * 2 + ph % 2) : ph;
    e.chk = chk;
    e.exp = model(shadow[idx], blank, p);
    e.tag = tag;
    sbq.push_back(e);
    @(posedge clk);
    cyc++;
    #1;
    if (sbq.size() == 3) begin
      o = sbq.pop_front();
      if (o.chk) begin
        obs = observed();
        n_cmp++;
        assert (obs === o.exp) else begin
          n_bad++;
          $error("FAIL %s: observed %h expected %h", o.tag, obs, o.exp);
        end
      end
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    cram_addr_in = a;
    cram_data_in = d;
    cram_we      = 1'b1;
    step(1'b0, "wr");
    cram_we      = 1'b0;
  endtask

  task automatic flush();
    repeat (3) step(1'b0, "flush");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) shadow[i] = 'x;
    tv_lat = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    check("reset_out", 32'(observed()), 32'd0);
    check("reset_rd", 32'(cram_rd_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;

    vga_on = 1'b1;
    wr(8'h00, 16'h0000);
    wr(8'h12, 16'h7FFF);
    wr(8'h05, 16'h2C00);   // red coarse 1 frac 3
    wr(8'h06, 16'h3400);   // red coarse 1 frac 5
    wr(8'h20, 16'h7D17);   // saturated red, frac 0 green, frac 7 blue
    wr(8'hAC, 16'h8421);
    wr(8'hA3, 16'h1CE7);
    wr(8'h40, 16'h0C63);
    flush();

    vgaplex = 8'h12;
    repeat (4) step(1'b1, "full_white");

    vgaplex = 8'h20;
    repeat (4) step(1'b1, "sat_frac0");
    flush();
    vga_line = 1'b1;
    repeat (4) step(1'b1, "sat_line1");

    vgaplex = 8'h06;
    flush();
    repeat (4) step(1'b1, "vga_line1_dither");
    flush();
    vga_line = 1'b0;
    repeat (4) step(1'b1, "vga_line0_dither");

    vgaplex = 8'h12;
    repeat (2) step(1'b1, "pre_blank");
    vga_blank = 1'b1;
    step(1'b1, "blank_pixel");
    vga_blank = 1'b0;
    repeat (2) step(1'b1, "post_blank");

    vga_hires = 1'b1; palsel = 4'hA; vgaplex = 8'h3C; plex_sel_in = 2'b01;
    repeat (3) step(1'b1, "hires_lo_nib");
    plex_sel_in = 2'b00;
    repeat (3) step(1'b1, "hires_hi_nib");
    vga_hires = 1'b0;

    vgaplex = 8'h40; cram_addr_in = 8'h40;
    step(1'b1, "coll_old_word");
    cram_data_in = 16'h1234; cram_we = 1'b1;
    step(1'b1, "coll_new_word");
    check("rd_old_on_write", 32'(cram_rd_data), 32'h0C63);
    cram_we = 1'b0;
    step(1'b1, "coll_after");
    check("rd_new_after", 32'(cram_rd_data), 32'h1234);

    flush();
    vga_on = 1'b0; c3 = 1'b1; vplex_in = 8'h05;
    repeat (8) step(1'b1, "tv_dither");
    c3 = 1'b0; vplex_in = 8'h12;
    repeat (4) step(1'b1, "tv_hold_no_c3");
    c3 = 1'b1;
    repeat (3) step(1'b1, "tv_new_index");
    tv_blank = 1'b1;
    step(1'b1, "tv_blank");
    tv_blank = 1'b0; vplex_in = 8'h05;
    repeat (4) step(1'b1, "tv_resume");

    #2 rst = 1'b1;
    #1;
    check("async_rst_out", 32'(observed()), 32'd0);
    check("async_rst_rd", 32'(cram_rd_data), 32'd0);
    sbq.delete();
    tv_lat = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    repeat (8) step(1'b1, "post_rst");

    flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
